// File: rtl/counter_cmd_sequencer_pkg.sv
// Shared definitions for the counter command sequencer: op codes, FSM states
// and the layout of one queued command.
package counter_seq_pkg;

   localparam int SEQ_DATA_W = 8;
   localparam int SEQ_ARG_W  = 8;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_RUN  = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   // One FIFO entry; op sits in the upper bits so {op, arg} packs directly.
   typedef struct packed {
      logic [1:0]           op;
      logic [SEQ_ARG_W-1:0] arg;
   } cmd_entry_t;

endpackage

// File: rtl/counter_cmd_sequencer_if.sv
// Command handshake bus between a host (master) and the sequencer (slave).
interface counter_cmd_sequencer_if #(
   parameter int ARG_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [ARG_W-1:0] cmd_arg;

   modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/counter_cmd_sequencer_fifo.sv
// Show-ahead synchronous FIFO for queued commands; the head entry is visible
// combinationally so the sequencer can pop and act on it in the same cycle.
module seq_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             do_wr;
   logic             do_rd;

   assign do_wr = wr_en && !full && !clr;
   assign do_rd = rd_en && !empty && !clr;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr_reg[AW-1:0]];
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
endmodule

// File: rtl/counter_cmd_sequencer.sv
// Executes queued LOAD/RUN/HOLD/NOP commands back-to-back and drives the
// smart counter's load, enable and data inputs from registers.
module counter_cmd_sequencer
   import counter_seq_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ARG_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   counter_cmd_sequencer_if.slave cmd,
   input  logic                  abort,
   output logic                  ctr_load,
   output logic                  ctr_enable,
   output logic [DATA_W-1:0]     ctr_data,
   output logic                  busy,
   output logic                  done
);
   state_t              state_reg, state_next;
   logic [ARG_W-1:0]    remaining_reg, remaining_next;
   logic                load_reg, load_next;
   logic                enable_reg, enable_next;
   logic [DATA_W-1:0]   data_reg, data_next;
   logic                done_reg, done_next;

   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic [ARG_W+1:0]    head;
   logic [1:0]          head_op;
   logic [ARG_W-1:0]    head_arg;
   logic [ARG_W-1:0]    head_remaining;
   logic                last_cycle;

   assign cmd.cmd_ready = !fifo_full && !abort;
   assign push          = cmd.cmd_valid && cmd.cmd_ready;

   seq_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ARG_W + 2)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (abort),
      .wr_en   (push),
      .wr_data ({cmd.cmd_op, cmd.cmd_arg}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign {head_op, head_arg} = head;
   // A count of zero is treated as one, so the terminal value is always zero.
   assign head_remaining = (head_arg == '0) ? '0 : head_arg - ARG_W'(1);
   assign last_cycle     = (state_reg == ST_IDLE) || (state_reg == ST_LOAD) ||
                           (remaining_reg == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         remaining_reg <= '0;
         load_reg      <= 1'b0;
         enable_reg    <= 1'b0;
         data_reg      <= '0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         load_reg      <= load_next;
         enable_reg    <= enable_next;
         data_reg      <= data_next;
         done_reg      <= done_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      data_next      = data_reg;
      load_next      = 1'b0;
      enable_next    = 1'b0;
      done_next      = 1'b0;
      pop            = 1'b0;

      if (abort) begin
         state_next     = ST_IDLE;
         remaining_next = '0;
      end else if (!last_cycle) begin
         remaining_next = remaining_reg - ARG_W'(1);
         enable_next    = (state_reg == ST_RUN);
         done_next      = (remaining_reg == ARG_W'(1));
      end else if (!fifo_empty) begin
         // Chain straight into the next command without an idle bubble.
         pop            = 1'b1;
         remaining_next = '0;
         case (head_op)
            OP_LOAD: begin
               state_next = ST_LOAD;
               load_next  = 1'b1;
               data_next  = head_arg[DATA_W-1:0];
               done_next  = 1'b1;
            end
            OP_RUN: begin
               state_next     = ST_RUN;
               remaining_next = head_remaining;
               enable_next    = 1'b1;
               done_next      = (head_remaining == '0);
            end
            OP_HOLD: begin
               state_next     = ST_HOLD;
               remaining_next = head_remaining;
               done_next      = (head_remaining == '0);
            end
            default: begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
         endcase
      end else begin
         state_next     = ST_IDLE;
         remaining_next = '0;
      end
   end

   assign ctr_load   = load_reg;
   assign ctr_enable = enable_reg;
   assign ctr_data   = data_reg;
   assign done       = done_reg;
   // done_reg keeps busy high through a NOP, which runs while the state is IDLE.
   assign busy       = (state_reg != ST_IDLE) || !fifo_empty || done_reg;
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench for counter_cmd_sequencer with a model of the downstream counter.
module tb_counter_cmd_sequencer;
   import counter_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       abort = 1'b0;
   logic       ctr_load;
   logic       ctr_enable;
   logic [7:0] ctr_data;
   logic       busy;
   logic       done;
   logic [7:0] cnt_model;
   int         n_asserts = 0;
   int         n_fails   = 0;
   int         stalls;

   counter_cmd_sequencer_if #(.ARG_W(8)) cmd_bus ();

   counter_cmd_sequencer #(
      .DATA_W     (8),
      .ARG_W      (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cmd_bus),
      .abort      (abort),
      .ctr_load   (ctr_load),
      .ctr_enable (ctr_enable),
      .ctr_data   (ctr_data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Downstream 8-bit counter fed by the sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          cnt_model <= 8'h00;
      else if (ctr_load)   cnt_model <= ctr_data;
      else if (ctr_enable) cnt_model <= cnt_model + 8'h01;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_strb(input string tag, input logic l, input logic e, input logic d);
      check({tag, "_load"},   32'(ctr_load),   32'(l));
      check({tag, "_enable"}, 32'(ctr_enable), 32'(e));
      check({tag, "_done"},   32'(done),       32'(d));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one command and returns after the edge that accepted it.
   task automatic push(input logic [1:0] op, input logic [7:0] arg, output int n_stall);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = op;
      cmd_bus.cmd_arg   = arg;
      n_stall = 0;
      while (!cmd_bus.cmd_ready && n_stall < 64) begin
         step();
         n_stall++;
      end
      if (!cmd_bus.cmd_ready) check("push_timeout", 32'(cmd_bus.cmd_ready), 32'd1);
      step();
      cmd_bus.cmd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_op    = OP_NOP;
      cmd_bus.cmd_arg   = 8'h00;

      // Reset state, with a push attempted while in reset
      step();
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = OP_RUN;
      cmd_bus.cmd_arg   = 8'h04;
      step();
      chk_strb("rst", 1'b0, 1'b0, 1'b0);
      check("rst_data",  32'(ctr_data), 32'h00);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      cmd_bus.cmd_valid = 1'b0;
      rst_n = 1'b1;
      step();
      step();
      check("rst_push_ignored_busy", 32'(busy), 32'd0);
      check("rst_push_ignored_en", 32'(ctr_enable), 32'd0);

      // LOAD 0x55 then RUN 3 chained without a gap
      push(OP_LOAD, 8'h55, stalls);
      push(OP_RUN, 8'h03, stalls);
      chk_strb("lr_c1", 1'b1, 1'b0, 1'b1);
      check("lr_c1_data", 32'(ctr_data), 32'h55);
      step(); chk_strb("lr_c2", 1'b0, 1'b1, 1'b0);
      check("lr_c2_data", 32'(ctr_data), 32'h55);
      step(); chk_strb("lr_c3", 1'b0, 1'b1, 1'b0);
      step(); chk_strb("lr_c4", 1'b0, 1'b1, 1'b1);
      check("lr_c4_busy", 32'(busy), 32'd1);
      step(); chk_strb("lr_c5", 1'b0, 1'b0, 1'b0);
      check("lr_c5_busy", 32'(busy), 32'd0);
      check("lr_counter", 32'(cnt_model), 32'h58);

      // HOLD 0 and RUN 0 each take one cycle
      push(OP_HOLD, 8'h00, stalls);
      push(OP_RUN, 8'h00, stalls);
      chk_strb("z_hold", 1'b0, 1'b0, 1'b1);
      check("z_hold_busy", 32'(busy), 32'd1);
      step(); chk_strb("z_run", 1'b0, 1'b1, 1'b1);
      step(); chk_strb("z_after", 1'b0, 1'b0, 1'b0);
      check("z_after_busy", 32'(busy), 32'd0);
      check("z_counter", 32'(cnt_model), 32'h59);

      // FIFO full: four queued behind RUN 10, the fifth waits for a pop
      push(OP_RUN, 8'h0A, stalls);
      push(OP_LOAD, 8'h11, stalls);
      push(OP_HOLD, 8'h02, stalls);
      push(OP_RUN, 8'h02, stalls);
      push(OP_NOP, 8'h00, stalls);
      check("full_4th_stalls", 32'(stalls), 32'd0);
      check("full_ready_low", 32'(cmd_bus.cmd_ready), 32'd0);
      check("full_running", 32'(ctr_enable), 32'd1);
      push(OP_LOAD, 8'h22, stalls);
      check("full_5th_stalls", 32'(stalls), 32'd7);
      chk_strb("ord_hold1", 1'b0, 1'b0, 1'b0);
      check("ord_load11_data", 32'(ctr_data), 32'h11);
      step(); chk_strb("ord_hold2", 1'b0, 1'b0, 1'b1);
      step(); chk_strb("ord_run1", 1'b0, 1'b1, 1'b0);
      step(); chk_strb("ord_run2", 1'b0, 1'b1, 1'b1);
      step(); chk_strb("ord_nop", 1'b0, 1'b0, 1'b1);
      check("ord_nop_busy", 32'(busy), 32'd1);
      step(); chk_strb("ord_load22", 1'b1, 1'b0, 1'b1);
      check("ord_load22_data", 32'(ctr_data), 32'h22);
      step(); check("ord_end_busy", 32'(busy), 32'd0);
      check("ord_counter", 32'(cnt_model), 32'h22);

      // Abort in cycle 3 of RUN 8 with two queued commands and a simultaneous push
      push(OP_RUN, 8'h08, stalls);
      push(OP_LOAD, 8'h33, stalls);
      push(OP_HOLD, 8'h04, stalls);
      step();
      check("ab_pre_enable", 32'(ctr_enable), 32'd1);
      abort = 1'b1;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = OP_LOAD;
      cmd_bus.cmd_arg   = 8'h44;
      #1;
      check("ab_ready_low", 32'(cmd_bus.cmd_ready), 32'd0);
      step();
      abort = 1'b0;
      cmd_bus.cmd_valid = 1'b0;
      #1;
      chk_strb("ab_after", 1'b0, 1'b0, 1'b0);
      check("ab_busy", 32'(busy), 32'd0);
      check("ab_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      check("ab_counter", 32'(cnt_model), 32'h25);
      step(); step(); step();
      chk_strb("ab_flushed", 1'b0, 1'b0, 1'b0);
      check("ab_flushed_data", 32'(ctr_data), 32'h22);
      check("ab_flushed_busy", 32'(busy), 32'd0);

      // LOAD 0xF0, RUN 0x20: counter wraps to 0x10
      push(OP_LOAD, 8'hF0, stalls);
      push(OP_RUN, 8'h20, stalls);
      chk_strb("wr_load", 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 32; i++) begin
         step();
         check("wr_run_en", 32'(ctr_enable), 32'd1);
         check("wr_run_data", 32'(ctr_data), 32'hF0);
         check("wr_run_done", 32'(done), 32'((i == 31) ? 1 : 0));
      end
      step();
      chk_strb("wr_end", 1'b0, 1'b0, 1'b0);
      check("wr_end_busy", 32'(busy), 32'd0);
      check("wr_counter", 32'(cnt_model), 32'h10);

      // Asynchronous reset mid-RUN with a queued entry
      push(OP_RUN, 8'h05, stalls);
      push(OP_LOAD, 8'h77, stalls);
      step();
      check("mr_pre_enable", 32'(ctr_enable), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_strb("mr_now", 1'b0, 1'b0, 1'b0);
      check("mr_now_data", 32'(ctr_data), 32'h00);
      check("mr_now_busy", 32'(busy), 32'd0);
      check("mr_now_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step(); step(); step();
      chk_strb("mr_after", 1'b0, 1'b0, 1'b0);
      check("mr_after_busy", 32'(busy), 32'd0);
      check("mr_after_data", 32'(ctr_data), 32'h00);
      check("mr_after_ready", 32'(cmd_bus.cmd_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end
endmodule
